// File: rtl/modbus_pkg.sv
// Shared constants for the Modbus register bank: function codes, exception
// codes and the request-sequencer state encoding.
package modbus_pkg;

    localparam logic [7:0] FC_READ_HOLD    = 8'h03;
    localparam logic [7:0] FC_READ_INPUT   = 8'h04;
    localparam logic [7:0] FC_WRITE_SINGLE = 8'h06;
    localparam logic [7:0] FC_WRITE_MULTI  = 8'h10;

    localparam logic [7:0] EXC_OK            = 8'h00;
    localparam logic [7:0] EXC_ILLEGAL_FUNC  = 8'h01;
    localparam logic [7:0] EXC_ILLEGAL_ADDR  = 8'h02;
    localparam logic [7:0] EXC_ILLEGAL_VALUE = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_READ   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    function automatic logic fc_is_read(input logic [7:0] f);
        return (f == FC_READ_HOLD) || (f == FC_READ_INPUT);
    endfunction

endpackage

// File: rtl/modbus_addr_check.sv
// Combinational validator for one register space: reports whether the function
// code targets this space, the resulting exception and the word offset.
module modbus_addr_check
    import modbus_pkg::*;
#(
    parameter int          N           = 8,
    parameter logic [15:0] BASE        = 16'h0000,
    parameter int          MAX_QTY     = 16,
    parameter bit          INPUT_SPACE = 1'b0
) (
    input  logic [7:0]  i_func,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_qty,
    output logic        o_hit,
    output logic [7:0]  o_exc,
    output logic [15:0] o_offset
);

    logic        w_single;
    logic [15:0] w_qty;
    logic [16:0] w_offset;
    logic [17:0] w_end;

    always_comb begin
        if (INPUT_SPACE) begin
            o_hit    = (i_func == FC_READ_INPUT);
            w_single = 1'b0;
        end else begin
            o_hit    = (i_func == FC_READ_HOLD) || (i_func == FC_WRITE_SINGLE) ||
                       (i_func == FC_WRITE_MULTI);
            w_single = (i_func == FC_WRITE_SINGLE);
        end
        w_qty    = w_single ? 16'd1 : i_qty;
        // Bit 16 of the 17-bit difference is the borrow: address below BASE.
        w_offset = {1'b0, i_addr} - {1'b0, BASE};
        w_end    = {1'b0, w_offset} + {2'b00, w_qty};
        o_exc    = EXC_OK;
        if (!w_single && ((i_qty == 16'd0) || (i_qty > 16'(MAX_QTY)))) begin
            o_exc = EXC_ILLEGAL_VALUE;
        end else if (w_offset[16] || (w_end > 18'(N))) begin
            o_exc = EXC_ILLEGAL_ADDR;
        end
        o_offset = w_offset[15:0];
    end

endmodule

// File: rtl/modbus_reg_bank.sv
// Modbus register bank serving read holding/input, write single and write
// multiple, with staged writes that commit to the holding registers atomically.
module modbus_reg_bank
    import modbus_pkg::*;
#(
    parameter int          N_IN      = 4,
    parameter int          N_HOLD    = 8,
    parameter logic [15:0] IN_BASE   = 16'h0000,
    parameter logic [15:0] HOLD_BASE = 16'h0000,
    parameter int          MAX_QTY   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [16*N_IN-1:0]    in_regs,
    output logic [16*N_HOLD-1:0]  hold_regs_o,
    output logic [N_HOLD-1:0]     hold_update,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [7:0]            req_func,
    input  logic [15:0]           req_addr,
    input  logic [15:0]           req_qty,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [15:0]           wr_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_data,
    output logic                  rsp_last,
    output logic                  done,
    output logic [7:0]            exc_code
);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_func;
    logic [15:0]        r_addr;
    logic [15:0]        r_qty;
    logic               r_space;        // 1: holding space, 0: input space
    logic [15:0]        r_idx;
    logic [15:0]        r_cnt;          // words left including the current one
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [15:0]        r_rsp_data;
    logic               r_rsp_last;
    logic [7:0]         r_exc;
    logic [N_HOLD-1:0]  r_hold_update;
    logic [15:0]        r_hold [N_HOLD];
    logic [15:0]        r_stage [N_HOLD];
    logic [N_HOLD-1:0]  r_stage_mask;

    logic [15:0]        w_in_words [N_IN];
    logic               w_in_hit;
    logic               w_hold_hit;
    logic [7:0]         w_in_exc;
    logic [7:0]         w_hold_exc;
    logic [15:0]        w_in_offset;
    logic [15:0]        w_hold_offset;
    logic [15:0]        w_offset;
    logic [7:0]         w_exc;
    logic [15:0]        w_sel_idx;
    logic [15:0]        w_sel_word;
    logic               w_req_fire;
    logic               w_rsp_fire;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_unpack
            assign w_in_words[gi] = in_regs[16*gi +: 16];
        end
        for (genvar gi = 0; gi < N_HOLD; gi++) begin : g_hold_pack
            assign hold_regs_o[16*gi +: 16] = r_hold[gi];
        end
    endgenerate

    modbus_addr_check #(
        .N(N_IN), .BASE(IN_BASE), .MAX_QTY(MAX_QTY), .INPUT_SPACE(1'b1)
    ) u_in_check (
        .i_func(r_func), .i_addr(r_addr), .i_qty(r_qty),
        .o_hit(w_in_hit), .o_exc(w_in_exc), .o_offset(w_in_offset)
    );

    modbus_addr_check #(
        .N(N_HOLD), .BASE(HOLD_BASE), .MAX_QTY(MAX_QTY), .INPUT_SPACE(1'b0)
    ) u_hold_check (
        .i_func(r_func), .i_addr(r_addr), .i_qty(r_qty),
        .o_hit(w_hold_hit), .o_exc(w_hold_exc), .o_offset(w_hold_offset)
    );

    assign w_req_fire = req_valid && r_req_ready;
    assign w_rsp_fire = r_rsp_valid && rsp_ready;

    // Word to load into rsp_data: the first word while checking, else the next one.
    always_comb begin
        w_offset = r_space ? w_hold_offset : w_in_offset;
        if (w_in_hit) begin
            w_exc = w_in_exc;
        end else if (w_hold_hit) begin
            w_exc = w_hold_exc;
        end else begin
            w_exc = EXC_ILLEGAL_FUNC;
        end
        w_sel_idx  = (r_state == ST_CHECK) ? w_offset : r_idx + 16'd1;
        w_sel_word = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (!r_space && (w_sel_idx == 16'(k))) w_sel_word = w_in_words[k];
        end
        for (int k = 0; k < N_HOLD; k++) begin
            if (r_space && (w_sel_idx == 16'(k))) w_sel_word = r_hold[k];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_req_fire) w_state_next = ST_CHECK;
            ST_CHECK: begin
                if (w_exc != EXC_OK)         w_state_next = ST_DONE;
                else if (fc_is_read(r_func)) w_state_next = ST_READ;
                else                         w_state_next = ST_WRITE;
            end
            ST_READ:   if (w_rsp_fire && r_rsp_last) w_state_next = ST_DONE;
            ST_WRITE:  if (wr_valid && (r_cnt == 16'd1)) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_func        <= '0;
            r_addr        <= '0;
            r_qty         <= '0;
            r_space       <= 1'b0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_last    <= 1'b0;
            r_exc         <= EXC_OK;
            r_hold_update <= '0;
            r_stage_mask  <= '0;
            for (int k = 0; k < N_HOLD; k++) r_hold[k] <= '0;
        end else begin
            r_state       <= w_state_next;
            r_req_ready   <= (w_state_next == ST_IDLE);
            r_hold_update <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_func  <= req_func;
                        r_addr  <= req_addr;
                        r_qty   <= req_qty;
                        r_space <= (req_func != FC_READ_INPUT);
                    end
                end
                ST_CHECK: begin
                    r_exc        <= w_exc;
                    r_idx        <= w_offset;
                    r_cnt        <= (r_func == FC_WRITE_SINGLE) ? 16'd1 : r_qty;
                    r_stage_mask <= '0;
                    if (w_state_next == ST_READ) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_sel_word;
                        r_rsp_last  <= (r_qty == 16'd1);
                    end
                end
                ST_READ: begin
                    if (w_rsp_fire) begin
                        if (r_rsp_last) begin
                            r_rsp_valid <= 1'b0;
                            r_rsp_last  <= 1'b0;
                        end else begin
                            r_idx      <= r_idx + 16'd1;
                            r_cnt      <= r_cnt - 16'd1;
                            r_rsp_data <= w_sel_word;
                            r_rsp_last <= (r_cnt == 16'd2);
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_valid) begin
                        if (r_cnt == 16'd1) begin
                            // Final word bypasses staging so every register lands on the same edge.
                            for (int k = 0; k < N_HOLD; k++) begin
                                if (r_stage_mask[k]) r_hold[k] <= r_stage[k];
                                if (r_idx == 16'(k)) r_hold[k] <= wr_data;
                                r_hold_update[k] <= r_stage_mask[k] || (r_idx == 16'(k));
                            end
                            r_stage_mask <= '0;
                        end else begin
                            for (int k = 0; k < N_HOLD; k++) begin
                                if (r_idx == 16'(k)) begin
                                    r_stage[k]      <= wr_data;
                                    r_stage_mask[k] <= 1'b1;
                                end
                            end
                            r_idx <= r_idx + 16'd1;
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign wr_ready    = (r_state == ST_WRITE);
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_last    = r_rsp_last;
    assign hold_update = r_hold_update;
    assign done        = (r_state == ST_DONE);
    assign exc_code    = done ? r_exc : EXC_OK;

endmodule

// File: tb/tb_modbus_reg_bank.sv
// Directed bench for modbus_reg_bank: reads, staged writes, exceptions and reset
// mid-write; a second instance with nonzero bases covers address underflow.
module tb_modbus_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [63:0]  in_regs;
    logic         req_valid, req_valid_b;
    logic [7:0]   req_func;
    logic [15:0]  req_addr, req_qty;
    logic         wr_valid;
    logic [15:0]  wr_data;
    logic         rsp_ready;

    logic [127:0] hold_regs_o, hold_regs_o_b;
    logic [7:0]   hold_update, hold_update_b;
    logic         req_ready, req_ready_b, wr_ready, wr_ready_b;
    logic         rsp_valid, rsp_valid_b, rsp_last, rsp_last_b, done, done_b;
    logic [15:0]  rsp_data, rsp_data_b;
    logic [7:0]   exc_code, exc_code_b;

    int n_checks = 0;
    int n_pass   = 0;

    modbus_reg_bank u_dut (
        .clk(clk), .rst(rst), .in_regs(in_regs),
        .hold_regs_o(hold_regs_o), .hold_update(hold_update),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_func(req_func), .req_addr(req_addr), .req_qty(req_qty),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .done(done), .exc_code(exc_code)
    );

    modbus_reg_bank #(.IN_BASE(16'h0010), .HOLD_BASE(16'h0010)) u_dut_b (
        .clk(clk), .rst(rst), .in_regs(in_regs),
        .hold_regs_o(hold_regs_o_b), .hold_update(hold_update_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_func(req_func), .req_addr(req_addr), .req_qty(req_qty),
        .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_data(wr_data),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b),
        .rsp_last(rsp_last_b), .done(done_b), .exc_code(exc_code_b)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns in the cycle after the request handshake (the check cycle).
    task automatic issue_req(input bit to_b, input logic [7:0] f, input logic [15:0] a,
                             input logic [15:0] q);
        logic rdy;
        req_func = f;
        req_addr = a;
        req_qty  = q;
        if (to_b) req_valid_b = 1'b1;
        else      req_valid   = 1'b1;
        rdy = to_b ? req_ready_b : req_ready;
        for (int i = 0; i < 20 && !rdy; i++) begin
            step();
            rdy = to_b ? req_ready_b : req_ready;
        end
        check_eq("req_ready_wait", rdy, 1'b1);
        step();
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        $display("req %s func=0x%02h addr=0x%04h qty=%0d", to_b ? "B" : "A", f, a, q);
    endtask

    task automatic exc_case(input bit to_b, input logic [7:0] f, input logic [15:0] a,
                            input logic [15:0] q, input logic [7:0] exp_exc);
        issue_req(to_b, f, a, q);
        check_eq("exc_done_early", to_b ? done_b : done, 1'b0);
        check_eq("exc_wr_ready_chk", to_b ? wr_ready_b : wr_ready, 1'b0);
        step();
        check_eq("exc_done", to_b ? done_b : done, 1'b1);
        check_eq("exc_code", to_b ? exc_code_b : exc_code, exp_exc);
        check_eq("exc_wr_ready", to_b ? wr_ready_b : wr_ready, 1'b0);
        step();
        check_eq("exc_done_clear", to_b ? done_b : done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd_exp [3];
        logic [15:0] wr_words [3];
        rd_exp   = '{16'h7414, 16'h2021, 16'h0402};
        wr_words = '{16'hAAAA, 16'hBBBB, 16'hCCCC};

        rst = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0;
        req_func = '0; req_addr = '0; req_qty = '0;
        wr_valid = 1'b0; wr_data = '0; rsp_ready = 1'b0;
        in_regs = {16'h0402, 16'h2021, 16'h7414, 16'h5347};

        // Reset state
        step(); step();
        check_eq("rst_req_ready", req_ready, 1'b0);
        check_eq("rst_hold_regs", hold_regs_o, 128'h0);
        check_eq("rst_hold_update", hold_update, 8'h00);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_exc", exc_code, 8'h00);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_wr_ready", wr_ready, 1'b0);
        rst = 1'b0;
        check_eq("rst_drop_ready_low", req_ready, 1'b0);
        step();
        check_eq("rst_drop_ready_high", req_ready, 1'b1);

        // 0x04 read addr 1 qty 3 with a stall before every word
        issue_req(1'b0, 8'h04, 16'h0001, 16'd3);
        check_eq("rd_check_no_valid", rsp_valid, 1'b0);
        check_eq("rd_check_req_ready", req_ready, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            check_eq("rd_valid", rsp_valid, 1'b1);
            rsp_ready = 1'b0;
            step();
            check_eq("rd_stall_valid", rsp_valid, 1'b1);
            check_eq("rd_stall_data", rsp_data, rd_exp[i]);
            rsp_ready = 1'b1;
            check_eq("rd_data", rsp_data, rd_exp[i]);
            check_eq("rd_last", rsp_last, (i == 2));
            step();
        end
        rsp_ready = 1'b0;
        check_eq("rd_done", done, 1'b1);
        check_eq("rd_exc", exc_code, 8'h00);
        check_eq("rd_valid_off", rsp_valid, 1'b0);
        step();
        check_eq("rd_done_clear", done, 1'b0);

        // 0x10 write addr 2 qty 3 with a gap before every word
        issue_req(1'b0, 8'h10, 16'h0002, 16'd3);
        step();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b0;
            step();
            check_eq("wr_ready", wr_ready, 1'b1);
            check_eq("wr_hold_unchanged", hold_regs_o, 128'h0);
            check_eq("wr_no_update", hold_update, 8'h00);
            wr_valid = 1'b1;
            wr_data  = wr_words[i];
            step();
        end
        wr_valid = 1'b0;
        check_eq("wr_commit_regs", hold_regs_o,
                 {48'h0, 16'hCCCC, 16'hBBBB, 16'hAAAA, 32'h0});
        check_eq("wr_commit_update", hold_update, 8'b0001_1100);
        check_eq("wr_commit_no_done", done, 1'b0);
        check_eq("wr_ready_off", wr_ready, 1'b0);
        step();
        check_eq("wr_done", done, 1'b1);
        check_eq("wr_exc", exc_code, 8'h00);
        check_eq("wr_update_pulse_end", hold_update, 8'h00);
        step();

        // 0x06 to addr 7 (qty field ignored), then 0x03 addr 6 qty 2 back to back
        issue_req(1'b0, 8'h06, 16'h0007, 16'd0);
        step();
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        step();
        wr_valid = 1'b0;
        check_eq("ws_update", hold_update, 8'h80);
        check_eq("ws_reg7", hold_regs_o[127:112], 16'h1234);
        step();
        check_eq("ws_done", done, 1'b1);
        check_eq("ws_exc", exc_code, 8'h00);
        step();
        rsp_ready = 1'b1;
        issue_req(1'b0, 8'h03, 16'h0006, 16'd2);
        step();
        check_eq("rh_valid0", rsp_valid, 1'b1);
        check_eq("rh_data0", rsp_data, 16'h0000);
        check_eq("rh_last0", rsp_last, 1'b0);
        step();
        check_eq("rh_valid1", rsp_valid, 1'b1);
        check_eq("rh_data1", rsp_data, 16'h1234);
        check_eq("rh_last1", rsp_last, 1'b1);
        step();
        check_eq("rh_done", done, 1'b1);
        check_eq("rh_exc", exc_code, 8'h00);
        check_eq("rh_valid_off", rsp_valid, 1'b0);
        rsp_ready = 1'b0;
        step();

        // Exceptions
        exc_case(1'b0, 8'h05, 16'h0000, 16'd1,  8'h01);
        exc_case(1'b0, 8'h03, 16'h0000, 16'd0,  8'h03);
        exc_case(1'b0, 8'h03, 16'h0000, 16'd17, 8'h03);
        exc_case(1'b0, 8'h03, 16'h0006, 16'd3,  8'h02);
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        exc_case(1'b1, 8'h10, 16'h000F, 16'd1, 8'h02);
        wr_valid = 1'b0;
        check_eq("b_no_update", hold_update_b, 8'h00);
        check_eq("b_regs_clean", hold_regs_o_b, 128'h0);

        // Nonzero base: input register 2 lives at address 0x12
        rsp_ready = 1'b1;
        issue_req(1'b1, 8'h04, 16'h0012, 16'd1);
        step();
        check_eq("b_rd_valid", rsp_valid_b, 1'b1);
        check_eq("b_rd_data", rsp_data_b, 16'h2021);
        check_eq("b_rd_last", rsp_last_b, 1'b1);
        step();
        check_eq("b_rd_done", done_b, 1'b1);
        rsp_ready = 1'b0;
        step();

        // Reset after two of three words of a 0x10 write
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        issue_req(1'b0, 8'h10, 16'h0000, 16'd3);
        step();
        wr_valid = 1'b1;
        wr_data  = 16'h1111;
        step();
        wr_data  = 16'h2222;
        step();
        wr_valid = 1'b0;
        rst = 1'b1;
        step();
        check_eq("mid_rst_update", hold_update, 8'h00);
        check_eq("mid_rst_regs", hold_regs_o, 128'h0);
        check_eq("mid_rst_done", done, 1'b0);
        check_eq("mid_rst_wr_ready", wr_ready, 1'b0);
        rst = 1'b0;
        check_eq("mid_rst_ready_low", req_ready, 1'b0);
        step();
        check_eq("mid_rst_ready_high", req_ready, 1'b1);
        check_eq("mid_rst_update_after", hold_update, 8'h00);
        check_eq("mid_rst_regs_after", hold_regs_o, 128'h0);

        // Staging discarded: a fresh single write touches only its own register
        issue_req(1'b0, 8'h06, 16'h0005, 16'd0);
        step();
        wr_valid = 1'b1;
        wr_data  = 16'h5555;
        step();
        wr_valid = 1'b0;
        check_eq("post_rst_update", hold_update, 8'h20);
        check_eq("post_rst_regs", hold_regs_o, {32'h0, 16'h5555, 80'h0});
        step();
        check_eq("post_rst_done", done, 1'b1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
